// File: rtl/sic_inject_seq_if.sv
// Fetch-side feed bundle for the single-instruction-check sequencer.
// master = environment (drives start/sym_inst/stall/commit); slave = sequencer.
interface sic_inject_seq_if;
  logic        start;
  logic [31:0] sym_inst;
  logic        fetch_stall;
  logic        commit_valid;
  logic [31:0] inst_out;
  logic        inst_valid;
  logic        check_en;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        spurious;
  logic [2:0]  state_dbg;

  modport master (
    output start, sym_inst, fetch_stall, commit_valid,
    input  inst_out, inst_valid, check_en, busy, done, timeout, spurious, state_dbg
  );

  modport slave (
    input  start, sym_inst, fetch_stall, commit_valid,
    output inst_out, inst_valid, check_en, busy, done, timeout, spurious, state_dbg
  );
endinterface

// File: rtl/sic_inject_seq.sv
// Single-instruction-check sequencer: NOP flush, inject one symbolic instruction,
// drain until it commits (or time out), then pulse check_en for the monitors.
module sic_inject_seq #(
  parameter int FLUSH_CYCLES = 4,
  parameter int DRAIN_MAX    = 32,
  parameter int CNT_W        = 6
) (
  input logic              clk,
  input logic              reset,
  sic_inject_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_INJECT = 3'd2,
    S_DRAIN  = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam logic [31:0]      NOP        = 32'h0000007F;
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      inst_q, inst_d;
  logic             timeout_q, timeout_d;
  logic             spurious_q, spurious_d;
  logic [31:0]      inst_out_q, inst_out_d;
  logic             inst_valid_q, inst_valid_d;
  logic             check_en_q, check_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Fetch handshake: the injected word transfers in an INJECT cycle with
  // fetch_stall low (fetch_stall is the inverse of ready). inst_valid only
  // qualifies the word as real; a symbolic NOP transfers with inst_valid low.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inst_d     = inst_q;
    timeout_d  = timeout_q;
    spurious_d = spurious_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          inst_d     = bus.sym_inst;
          cnt_d      = '0;
          timeout_d  = 1'b0;
          spurious_d = 1'b0;
          state_d    = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (bus.commit_valid) spurious_d = 1'b1;
        if (cnt_q == FLUSH_LAST) begin
          cnt_d   = '0;
          state_d = S_INJECT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_INJECT: begin
        if (bus.commit_valid) spurious_d = 1'b1;
        if (!bus.fetch_stall) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // A commit on the final drain cycle still counts as a commit.
        if (bus.commit_valid) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else if (cnt_q == DRAIN_LAST) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        cnt_d   = '0;
        state_d = S_DONE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they are pure Moore.
  always_comb begin
    inst_out_d   = (state_d == S_INJECT) ? inst_d : NOP;
    inst_valid_d = (state_d == S_INJECT) && (inst_d[6:0] != 7'h7F);
    check_en_d   = (state_d == S_CHECK);
    busy_d       = (state_d == S_FLUSH) || (state_d == S_INJECT) ||
                   (state_d == S_DRAIN) || (state_d == S_CHECK);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      inst_q       <= NOP;
      timeout_q    <= 1'b0;
      spurious_q   <= 1'b0;
      inst_out_q   <= NOP;
      inst_valid_q <= 1'b0;
      check_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      inst_q       <= inst_d;
      timeout_q    <= timeout_d;
      spurious_q   <= spurious_d;
      inst_out_q   <= inst_out_d;
      inst_valid_q <= inst_valid_d;
      check_en_q   <= check_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.inst_out   = inst_out_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.check_en   = check_en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.spurious   = spurious_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_sic_inject_seq.sv
// Bench for sic_inject_seq: per-run stimulus tables, expected waveform derived
// from phase boundaries (inject/accept/commit cycles) computed from the run's inputs.
module tb_sic_inject_seq;
  localparam int          F   = 4;
  localparam int          DM  = 32;
  localparam int          AN  = 128;
  localparam logic [31:0] NOP = 32'h0000007F;
  localparam logic [31:0] ADD = 32'h00208033;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sic_inject_seq_if bus ();

  sic_inject_seq #(.FLUSH_CYCLES(F), .DRAIN_MAX(DM), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  logic stall_a  [0:AN-1];
  logic commit_a [0:AN-1];
  logic start_a  [0:AN-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_tables();
    for (int i = 0; i < AN; i++) begin
      stall_a[i]  = 1'b0;
      commit_a[i] = 1'b0;
      start_a[i]  = 1'b0;
    end
  endtask

  function automatic int accept_cycle();
    int a;
    a = F + 1;
    while (stall_a[a] && a < AN - DM - 8) a++;
    return a;
  endfunction

  // Start issued at cycle 0; outputs of cycle k reflect inputs up to cycle k-1.
  task automatic run_seq(input logic [31:0] sym, input bit noisy_start, input string name);
    int inj, acc, ds, c, done_s, sp, end_k;
    bit found, in_inj;
    logic [31:0] e_out;
    inj = F + 1;
    acc = accept_cycle();
    ds  = acc + 1;
    found = 1'b0;
    c = -1;
    for (int j = ds; j < ds + DM; j++)
      if (!found && commit_a[j]) begin found = 1'b1; c = j; end
    done_s = found ? c + 2 : ds + DM;
    sp = -1;
    for (int j = acc; j >= 1; j--) if (commit_a[j]) sp = j;
    for (int j = 1; j < AN; j++)
      start_a[j] = (noisy_start && j < done_s) ? 1'($urandom_range(0, 1)) : 1'b0;
    end_k = done_s + 1;

    for (int k = 0; k <= end_k; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        in_inj = (k >= inj) && (k <= acc);
        e_out  = in_inj ? sym : NOP;
        chk($sformatf("%s k=%0d inst_out", name, k), bus.inst_out, e_out);
        chk($sformatf("%s k=%0d inst_valid", name, k), 32'(bus.inst_valid),
            32'(in_inj && sym[6:0] != 7'h7F));
        chk($sformatf("%s k=%0d check_en", name, k), 32'(bus.check_en), 32'(found && k == c + 1));
        chk($sformatf("%s k=%0d busy", name, k), 32'(bus.busy), 32'(k < done_s));
        chk($sformatf("%s k=%0d done", name, k), 32'(bus.done), 32'(k >= done_s));
        chk($sformatf("%s k=%0d timeout", name, k), 32'(bus.timeout), 32'(!found && k >= done_s));
        chk($sformatf("%s k=%0d spurious", name, k), 32'(bus.spurious), 32'(sp >= 0 && k > sp));
      end
      bus.start        = (k == 0) ? 1'b1 : start_a[k];
      bus.sym_inst     = (k == 0) ? sym : $urandom();
      bus.fetch_stall  = stall_a[k];
      bus.commit_valid = commit_a[k];
    end
    bus.start        = 1'b0;
    bus.fetch_stall  = 1'b0;
    bus.commit_valid = 1'b0;
  endtask

  task automatic gen_random(input int mode);
    int acc, ds;
    clear_tables();
    for (int k = 0; k <= F + 6; k++) stall_a[k] = 1'($urandom_range(0, 1));
    acc = accept_cycle();
    ds  = acc + 1;
    for (int k = 1; k <= acc; k++) commit_a[k] = ($urandom_range(0, 5) == 0);
    case (mode)
      0: ;
      1: commit_a[ds + $urandom_range(0, DM - 1)] = 1'b1;
      2: commit_a[ds + DM - 1] = 1'b1;
      default: for (int k = ds; k < ds + DM; k++) commit_a[k] = ($urandom_range(0, 9) == 0);
    endcase
    for (int k = ds + DM; k < AN; k++) commit_a[k] = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    logic [31:0] sym;
    bus.start        = 1'b0;
    bus.sym_inst     = '0;
    bus.fetch_stall  = 1'b0;
    bus.commit_valid = 1'b0;
    reset            = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst inst_out", bus.inst_out, NOP);
    chk("rst inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst check_en", 32'(bus.check_en), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst timeout", 32'(bus.timeout), 32'd0);
    chk("rst spurious", 32'(bus.spurious), 32'd0);
    reset = 1'b0;

    // nominal: commit on cycle 8, check_en at 9
    clear_tables();
    commit_a[8] = 1'b1;
    run_seq(ADD, 1'b0, "nominal");

    // stall cycles 5-7, accept at 8
    clear_tables();
    stall_a[5] = 1'b1; stall_a[6] = 1'b1; stall_a[7] = 1'b1;
    commit_a[11] = 1'b1;
    run_seq(ADD, 1'b0, "stall");

    // no commit: timeout 32 cycles after drain entry
    clear_tables();
    run_seq(ADD, 1'b0, "timeout");

    // commit on the 32nd drain cycle wins over timeout
    clear_tables();
    commit_a[6 + DM - 1] = 1'b1;
    run_seq(ADD, 1'b0, "lastdrain");

    // spurious commit in flush, start pulses while busy
    clear_tables();
    commit_a[2] = 1'b1;
    commit_a[10] = 1'b1;
    run_seq(ADD, 1'b1, "spurious");

    // timeout run then restart from DONE with a symbolic NOP
    clear_tables();
    run_seq(32'h00310133, 1'b0, "pre_nop");
    clear_tables();
    commit_a[3] = 1'b1;
    run_seq(NOP, 1'b0, "symnop");

    // reset mid-check during a stalled INJECT
    clear_tables();
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == F + 2) chk("midrst inject_valid", 32'(bus.inst_valid), 32'd1);
      bus.start        = (k == 0);
      bus.sym_inst     = ADD;
      bus.fetch_stall  = 1'b1;
      bus.commit_valid = (k == 2);
      reset            = (k == 8);
    end
    @(negedge clk);
    reset           = 1'b0;
    bus.fetch_stall = 1'b0;
    bus.commit_valid = 1'b0;
    chk("midrst inst_out", bus.inst_out, NOP);
    chk("midrst inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("midrst busy", 32'(bus.busy), 32'd0);
    chk("midrst done", 32'(bus.done), 32'd0);
    chk("midrst timeout", 32'(bus.timeout), 32'd0);
    chk("midrst spurious", 32'(bus.spurious), 32'd0);

    // randomized runs
    for (int r = 0; r < 32; r++) begin
      sym = $urandom();
      if ($urandom_range(0, 3) == 0) sym[6:0] = 7'h7F;
      gen_random(r % 4);
      run_seq(sym, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sic_inject_seq.md
Name: sic_inject_seq

Overview:
- Sequencer for single-instruction checking on the ridecore pipeline. Owns the fetch-side instruction feed.
- Per check, it flushes the pipeline with NOPs, injects one constrained symbolic instruction, then drains with NOPs until that instruction commits.
- It then pulses a one-cycle check-enable for the property monitors. The legality constraint is applied upstream on sym_inst.

Parameters:
- FLUSH_CYCLES, 4: NOP cycles before injection; valid range 1..2^CNT_W-1.
- DRAIN_MAX, 32: cycles to wait for commit before timeout; valid range 1..2^CNT_W-1.
- CNT_W, 6: width of the shared cycle counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a check; sampled only in IDLE or DONE.
- sym_inst  in  32  symbolic instruction; captured into inst_q on an accepted start.
- fetch_stall  in  1  fetch not accepting this cycle.
- commit_valid  in  1  the pipeline committed an instruction this cycle.
- inst_out  out  32  instruction presented to fetch.
- inst_valid  out  1  inst_out is a real instruction.
- check_en  out  1  one-cycle pulse: compare architectural state now.
- busy  out  1  high in FLUSH, INJECT, DRAIN and CHECK.
- done  out  1  high in DONE.
- timeout  out  1  sticky; the check ended without a commit.
- spurious  out  1  sticky; commit_valid seen in FLUSH or INJECT.

Behaviour:
- Encoding: NOP = 32'h0000007F (opcode 7'b1111111). Whenever inst_out is NOP, inst_valid = 0.
- Outputs are Moore: they depend only on registers. There is no combinational path from any input to any output.
- Reset: state = IDLE, counter = 0, inst_q = NOP, inst_out = NOP, inst_valid = 0, check_en = 0, busy = 0, done = 0, timeout = 0, spurious = 0. Reset overrides everything, including mid-check; the next cycle is IDLE.
- IDLE: drives NOP.
  - start = 1 at edge t: capture inst_q <= sym_inst, clear the counter, timeout and spurious, and go to FLUSH.
- FLUSH: drives NOP.
  - The state lasts exactly FLUSH_CYCLES cycles (t+1 .. t+FLUSH_CYCLES), then goes to INJECT.
  - A commit_valid here sets spurious.
- INJECT: inst_out = inst_q.
  - inst_valid = 1, unless inst_q[6:0] == 7'h7F (a symbolic NOP), in which case inst_valid = 0.
  - The instruction is held stable while fetch_stall = 1. There is no bound on the stall.
  - In the first cycle with fetch_stall = 0 the instruction is accepted: clear the counter and go to DRAIN.
  - A commit_valid in any INJECT cycle, including the accept cycle, sets spurious and is not counted as the injected commit.
  - Symbolic-NOP case: the inst_valid = 0 injection is still "accepted" on fetch_stall = 0. DRAIN then normally ends in timeout, and that outcome is legal.
- DRAIN: drives NOP; the counter increments every cycle.
  - commit_valid = 1: go to CHECK.
  - Otherwise, when the counter reaches DRAIN_MAX-1 (DRAIN_MAX cycles elapsed): set timeout and go to DONE.
  - If commit_valid arrives in the same cycle the limit is reached, the commit wins: go to CHECK, timeout stays 0.
- CHECK: drives NOP, check_en = 1 for exactly one cycle, then DONE.
- DONE: drives NOP; done = 1. timeout and spurious hold.
  - start = 1 restarts the sequence exactly as from IDLE.
- start is ignored in FLUSH, INJECT, DRAIN and CHECK.
- fetch_stall is ignored in every state except INJECT.
- check_en and timeout are never both asserted in one check.
- Counter: unsigned CNT_W bits, cleared on every state entry; it never wraps inside the valid parameter ranges.
- Minimum start-to-check_en latency: FLUSH_CYCLES + 3 cycles (no stall, commit on the first DRAIN cycle).

Test Plan:
- Nominal: FLUSH_CYCLES=4, start at cycle 0, sym_inst=32'h00208033 (ADD), no stall, commit_valid at cycle 8 → FLUSH cycles 1-4; INJECT cycle 5 with inst_out=32'h00208033 and inst_valid=1; DRAIN cycles 6-8; check_en=1 only at cycle 9; done=1 from cycle 10; timeout=0; spurious=0.
- Stall: as the nominal case but fetch_stall=1 for cycles 5-7 → inst_out holds 32'h00208033 with inst_valid=1 through cycles 5-8; accept at cycle 8; DRAIN from cycle 9; sym_inst changing after cycle 0 has no effect on inst_out.
- Timeout: DRAIN_MAX=32, no commit → timeout=1 and done=1 exactly 32 cycles after DRAIN entry; check_en never asserted. A second run with commit_valid on the 32nd DRAIN cycle → CHECK entered, timeout=0.
- Spurious/ignored inputs: commit_valid at cycle 2 (FLUSH) → spurious=1 sticky, sequence unaffected. start pulses during DRAIN → ignored.
- Reset mid-check: reset=1 during INJECT with fetch_stall=1 → next cycle IDLE with inst_out=32'h0000007F, inst_valid=0, busy=0, done=0, timeout=0, spurious=0.
- Restart and symbolic NOP: start in DONE with sym_inst=32'h0000007F → inst_valid stays 0 throughout the run, timeout=1 at the end, and done/timeout from the previous run are cleared on the restart.
